// File: rtl/inst_buffer_pkg.sv
// Shared MIPS decode constants and field-extract macros for the instruction buffer.
`ifndef INST_BUFFER_PKG_MACROS
`define INST_BUFFER_PKG_MACROS
`define GET_OP(w)   w[31:26]
`define GET_FUNC(w) w[5:0]
`endif

package inst_buffer_pkg;

  typedef enum logic [5:0] {
    OP_SPEC   = 6'h00,
    OP_REGIMM = 6'h01,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_BLEZ   = 6'h06,
    OP_BGTZ   = 6'h07
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR   = 6'h08,
    FN_JALR = 6'h09
  } func_e;

endpackage

// File: rtl/ib_predecode.sv
// Branch/jump predecode for one fetch lane.
// Latency: combinational, no state.
// Backpressure: none; evaluated on every lane regardless of valid.
module ib_predecode
  import inst_buffer_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] inst,
  output logic          br
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = `GET_OP(inst);
  assign fn          = `GET_FUNC(inst);
  assign unused_bits = ^inst[25:6];

  always_comb begin
    br = 1'b0;
    case (op)
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: br = 1'b1;
      OP_SPEC: br = (fn == FN_JR) || (fn == FN_JALR);
      default: br = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_buffer.sv
// Instruction queue between fetch and decode with branch/delay-slot tagging.
// Latency: 1 cycle enqueue-to-output, no empty bypass.
// Backpressure: in_ready drops unless FETCH_W entries are free; flush overrides push/pop.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int IW      = 32,
  parameter int PCW     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           flush_keep_ds,
  input  logic [FETCH_W-1:0]             in_valid,
  input  logic [FETCH_W*IW-1:0]          in_inst,
  input  logic [FETCH_W*PCW-1:0]         in_pc,
  output logic                           in_ready,
  output logic [ISSUE_W-1:0]             out_valid,
  output logic [ISSUE_W*IW-1:0]          out_inst,
  output logic [ISSUE_W*PCW-1:0]         out_pc,
  output logic [ISSUE_W-1:0]             out_br,
  output logic [ISSUE_W-1:0]             out_ds,
  input  logic [$clog2(ISSUE_W+1)-1:0]   out_take,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [IW-1:0]  inst;
    logic [PCW-1:0] pc;
    logic           br;
    logic           ds;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              lane_ent [FETCH_W];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic                last_push_br;
  logic [FETCH_W-1:0]  lane_br;
  logic [FETCH_W-1:0]  lane_ds;
  logic [CW-1:0]       npush;
  logic                last_br_next;
  logic                push;
  logic                keep_head;

  for (genvar i = 0; i < FETCH_W; i++) begin : g_lane
    ib_predecode #(.IW(IW)) u_predecode (
      .inst (in_inst[i*IW +: IW]),
      .br   (lane_br[i])
    );
  end

  // A lane is a delay slot when the instruction just before it in program
  // order was a branch, including across push boundaries.
  always_comb begin
    lane_ds      = '0;
    npush        = '0;
    last_br_next = last_push_br;
    lane_ds[0]   = last_push_br;
    for (int l = 1; l < FETCH_W; l++) begin
      lane_ds[l] = lane_br[l-1];
    end
    for (int l = 0; l < FETCH_W; l++) begin
      lane_ent[l] = '{inst: in_inst[l*IW +: IW], pc: in_pc[l*PCW +: PCW],
                      br: lane_br[l], ds: lane_ds[l]};
      if (in_valid[l]) begin
        npush        = npush + CW'(1);
        last_br_next = lane_br[l];
      end
    end
  end

  assign in_ready  = (count <= CW'(DEPTH - FETCH_W));
  assign push      = in_ready && (|in_valid) && !flush;
  assign keep_head = flush_keep_ds && (count != '0) && mem[rptr].ds;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      last_push_br <= 1'b0;
    end else if (flush) begin
      last_push_br <= 1'b0;
      if (keep_head) begin
        count <= CW'(1);
        wptr  <= rptr + PW'(1);
      end else begin
        count <= '0;
        rptr  <= wptr;
      end
    end else begin
      rptr  <= rptr + PW'(out_take);
      count <= count + (push ? npush : '0) - CW'(out_take);
      if (push) begin
        wptr         <= wptr + PW'(npush);
        last_push_br <= last_br_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int l = 0; l < FETCH_W; l++) begin
        if (in_valid[l]) mem[wptr + PW'(l)] <= lane_ent[l];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    out_br    = '0;
    out_ds    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      out_valid[k]             = (count > CW'(k));
      out_inst[k*IW +: IW]     = mem[rptr + PW'(k)].inst;
      out_pc[k*PCW +: PCW]     = mem[rptr + PW'(k)].pc;
      out_br[k]                = out_valid[k] & mem[rptr + PW'(k)].br;
      out_ds[k]                = out_valid[k] & mem[rptr + PW'(k)].ds;
    end
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Parametrised instruction queue between IF and ID.
- Accepts up to FETCH_W instructions per cycle from fetch and presents up to ISSUE_W oldest entries to the decoder(s).
- Predecodes branches at enqueue and tags every delay-slot instruction, so a multi-issue decode stage keeps branch/delay-slot pairing without re-deriving it.
- Supports pipeline flush, with an option to retain a pending delay slot.

Parameters:
- DEPTH, 8: number of entries; power of 2, at least 2*FETCH_W.
- FETCH_W, 2: enqueue lanes per cycle (1..4).
- ISSUE_W, 2: dequeue lanes per cycle (1..2).
- IW, 32: instruction width.
- PCW, 32: PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discard buffer contents (exception, eret, mispredict).
- flush_keep_ds  in  1  with flush: retain the head entry if it is a delay slot.
- in_valid  in  FETCH_W  per-lane valid; set lanes must be contiguous from lane 0.
- in_inst  in  FETCH_W*IW  lane i at bits [i*IW +: IW].
- in_pc  in  FETCH_W*PCW  lane PCs.
- in_ready  out  1  free entries >= FETCH_W.
- out_valid  out  ISSUE_W  slot k holds the k-th oldest entry; thermometer-coded.
- out_inst  out  ISSUE_W*IW  slot instructions.
- out_pc  out  ISSUE_W*PCW  slot PCs.
- out_br  out  ISSUE_W  slot is a branch/jump.
- out_ds  out  ISSUE_W  slot is a delay slot.
- out_take  in  $clog2(ISSUE_W+1)  number of slots consumed this cycle.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async, rst=1): wptr=rptr=0, count=0, out_valid=0, out_br=0, out_ds=0, in_ready=1, last_push_br=0.
- Push:
  - Occurs when in_ready && |in_valid.
  - npush = number of set lanes. Lane i is written to entry (wptr+i) mod DEPTH; wptr advances by npush, wrapping modulo DEPTH.
  - in_valid asserted while in_ready=0 is ignored (no write, no state change).
- Predecode per lane (ib_predecode), stored with the entry:
  - br = opcode in 1..7 (REGIMM, J, JAL, BEQ, BNE, BLEZ, BGTZ), or (opcode==SPEC && func in {JR, JALR}).
  - ds(lane0) = last_push_br; ds(lane i>0) = br(lane i-1).
  - After a push, last_push_br = br of the highest valid lane.
- Pop:
  - out_take entries leave the head; rptr advances mod DEPTH.
  - out_take > number of set out_valid bits is illegal; bench asserts on it.
- Outputs:
  - Combinational from the storage array at rptr..rptr+ISSUE_W-1.
  - out_valid[k] = (count > k).
  - Enqueue-to-output latency is 1 cycle. No bypass when empty.
- Simultaneous push and pop: count_next = count + npush - out_take. Push uses in_ready computed from current count, not count_next.
- Full: in_ready=0 once count > DEPTH-FETCH_W.
- Empty: out_valid all 0; out_take must be 0.
- Flush (highest priority; push and pop in the same cycle are ignored):
  - Default: count=0, rptr=wptr, last_push_br=0.
  - If flush_keep_ds=1 and the head entry has ds=1 and count>0: only the head is kept (count=1, wptr=rptr+1), and last_push_br=0.
  - If flush_keep_ds=1 but the head is not a delay slot: behaves as the default flush.
  - After flush, in_ready follows the new count in the next cycle.
- Pointer width: $clog2(DEPTH); wrap is natural overflow. count is kept separately to distinguish full from empty.

Decomposition:
- Shared header/package holds:
  - opcode constants (SPEC, REGIMM, J, JAL, BEQ, BNE, BLEZ, BGTZ);
  - func constants (JR, JALR);
  - field-extract macros (GET_OP, GET_FUNC).
- Sub-module ib_predecode: one instance per fetch lane. Purely combinational; instruction in, br out.
- Storage array, pointers and count live in inst_buffer.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=00, count=0.
- Push 2 lanes {0x24010001@0xBFC00000, 0x24020002@0xBFC00004}, out_take=0 -> next cycle out_valid=11, out_pc={0xBFC00004,0xBFC00000}, out_br=00, count=2.
- Push BEQ 0x10220003 in lane 1, then its delay slot in lane 0 of the next push -> the BEQ entry has br=1; the next entry has ds=1 (ds carried across pushes).
- Fill to DEPTH=8 with FETCH_W=2 -> in_ready drops when count=7 and stays 0 at count 8. Pop 2 while pushing 2 at count=6 -> count stays 6. Pointers wrap correctly after 5 rounds.
- Head is a ds entry (count=4); flush=1, flush_keep_ds=1 -> next cycle count=1 and the head PC is unchanged. Same with flush_keep_ds=0 -> count=0.
- Flush together with push and out_take=2 -> push and pop are ignored, count=0, and the following push has ds=0 on lane 0.
